// File: rtl/jt51_acc_ctrl_if.sv
// jt51_acc_ctrl_if
// Bundles the signals of the jt51 accumulator slot sequencer.
//   Host side (master drives):   cen, wr, wr_ch, wr_rl, wr_con
//   Sequencer side (slave drives): slot, m1_enters, m2_enters, c1_enters,
//                                  c2_enters, op31_acc, rl_I, con_I, sample
// The clock and reset stay outside the interface as plain module ports.
interface jt51_acc_ctrl_if;
    logic       cen;
    logic       wr;
    logic [2:0] wr_ch;
    logic [1:0] wr_rl;
    logic [2:0] wr_con;

    logic [4:0] slot;
    logic       m1_enters;
    logic       m2_enters;
    logic       c1_enters;
    logic       c2_enters;
    logic       op31_acc;
    logic [1:0] rl_I;
    logic [2:0] con_I;
    logic       sample;

    modport master (
        output cen, wr, wr_ch, wr_rl, wr_con,
        input  slot, m1_enters, m2_enters, c1_enters, c2_enters,
               op31_acc, rl_I, con_I, sample
    );

    modport slave (
        input  cen, wr, wr_ch, wr_rl, wr_con,
        output slot, m1_enters, m2_enters, c1_enters, c2_enters,
               op31_acc, rl_I, con_I, sample
    );
endinterface

// File: rtl/jt51_acc_ctrl.sv
// jt51_acc_ctrl
// Slot sequencer and channel-configuration store for the jt51 output
// accumulator. A 5-bit slot counter walks the 32-slot frame
// (group = cnt[4:3]: M1, M2, C1, C2; channel = cnt[2:0]). Each cen the
// slot-derived outputs are decoded from the counter, registered once, then
// passed through a DLY-deep cen-gated delay line so every field stays
// aligned with the operator pipeline.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - jt51_acc_ctrl_if.slave: cen, host channel write (wr, wr_ch,
//          wr_rl, wr_con) and the slot outputs (slot, *_enters, op31_acc,
//          rl_I, con_I, sample)
// Parameter:
//   DLY  - extra cen-qualified delay stages (0..7) on every output field
module jt51_acc_ctrl #(
    parameter int DLY = 0
) (
    input  logic            clk,
    input  logic            rst,
    jt51_acc_ctrl_if.slave  bus
);

    // One slot's worth of outputs; moved as a unit so no field can skew.
    typedef struct packed {
        logic [4:0] slot;
        logic       m1;
        logic       m2;
        logic       c1;
        logic       c2;
        logic       op31;
        logic       sample;
        logic [1:0] rl;
        logic [2:0] con;
    } bundle_t;

    // Reset contents equal the decode of slot 0 with a reset register file.
    localparam bundle_t RST_BUNDLE = '{
        slot:   5'd0,
        m1:     1'b1,
        m2:     1'b0,
        c1:     1'b0,
        c2:     1'b0,
        op31:   1'b0,
        sample: 1'b0,
        rl:     2'b11,
        con:    3'd0
    };

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic [4:0] regs_q [0:7];
    bundle_t    dec_d;
    bundle_t    pipe_q [0:DLY];

    assign cnt_d = cnt_q + 5'd1;

    // Slot decode. The register file read uses the pre-write contents, so a
    // write landing on the channel being read this cen shows up only on that
    // channel's next occurrence.
    always_comb begin
        dec_d        = RST_BUNDLE;
        dec_d.slot   = cnt_q;
        dec_d.m1     = (cnt_q[4:3] == 2'd0);
        dec_d.m2     = (cnt_q[4:3] == 2'd1);
        dec_d.c1     = (cnt_q[4:3] == 2'd2);
        dec_d.c2     = (cnt_q[4:3] == 2'd3);
        dec_d.op31   = (cnt_q == 5'd31);
        dec_d.sample = (cnt_q == 5'd16);
        dec_d.rl     = regs_q[cnt_q[2:0]][4:3];
        dec_d.con    = regs_q[cnt_q[2:0]][2:0];
    end

    // Slot counter and channel register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 5'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= {2'b11, 3'd0};
            end
        end else if (bus.cen) begin
            cnt_q <= cnt_d;
            if (bus.wr) begin
                regs_q[bus.wr_ch] <= {bus.wr_rl, bus.wr_con};
            end
        end
    end

    // Output register (stage 0) followed by DLY delay stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DLY; i++) begin
                pipe_q[i] <= RST_BUNDLE;
            end
        end else if (bus.cen) begin
            pipe_q[0] <= dec_d;
            for (int i = 1; i <= DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.slot      = pipe_q[DLY].slot;
    assign bus.m1_enters = pipe_q[DLY].m1;
    assign bus.m2_enters = pipe_q[DLY].m2;
    assign bus.c1_enters = pipe_q[DLY].c1;
    assign bus.c2_enters = pipe_q[DLY].c2;
    assign bus.op31_acc  = pipe_q[DLY].op31;
    assign bus.sample    = pipe_q[DLY].sample;
    assign bus.rl_I      = pipe_q[DLY].rl;
    assign bus.con_I     = pipe_q[DLY].con;

endmodule

// File: tb/tb_jt51_acc_ctrl.sv
// tb_jt51_acc_ctrl
// Drives two sequencers (DLY=0 and DLY=3) with identical stimulus. A model
// of the frame and register file pushes the expected output bundle into a
// queue per DUT when a cen is driven; the bundle is popped and compared once
// the DUT has clocked it out.
module tb_jt51_acc_ctrl;

    typedef struct packed {
        logic [4:0] slot;
        logic       m1;
        logic       m2;
        logic       c1;
        logic       c2;
        logic       op31;
        logic       sample;
        logic [1:0] rl;
        logic [2:0] con;
    } bundle_t;

    localparam bundle_t RST_B = '{
        slot: 5'd0, m1: 1'b1, m2: 1'b0, c1: 1'b0, c2: 1'b0,
        op31: 1'b0, sample: 1'b0, rl: 2'b11, con: 3'd0
    };

    logic clk;
    logic rst;

    jt51_acc_ctrl_if bus0 ();
    jt51_acc_ctrl_if bus3 ();

    jt51_acc_ctrl #(.DLY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    jt51_acc_ctrl #(.DLY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bundle_t out0;
    bundle_t out3;
    assign out0 = '{slot: bus0.slot, m1: bus0.m1_enters, m2: bus0.m2_enters,
                    c1: bus0.c1_enters, c2: bus0.c2_enters, op31: bus0.op31_acc,
                    sample: bus0.sample, rl: bus0.rl_I, con: bus0.con_I};
    assign out3 = '{slot: bus3.slot, m1: bus3.m1_enters, m2: bus3.m2_enters,
                    c1: bus3.c1_enters, c2: bus3.c2_enters, op31: bus3.op31_acc,
                    sample: bus3.sample, rl: bus3.rl_I, con: bus3.con_I};

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state
    logic [4:0] m_cnt;
    logic [4:0] m_regs [0:7];
    bundle_t    q0 [$];
    bundle_t    q3 [$];
    bundle_t    exp0;
    bundle_t    exp3;

    function automatic bundle_t model_decode(input logic [4:0] s, input logic [4:0] r);
        bundle_t b;
        b.slot   = s;
        b.m1     = (s < 5'd8);
        b.m2     = (s >= 5'd8)  && (s < 5'd16);
        b.c1     = (s >= 5'd16) && (s < 5'd24);
        b.c2     = (s >= 5'd24);
        b.op31   = (s == 5'd31);
        b.sample = (s == 5'd16);
        b.rl     = r[4:3];
        b.con    = r[2:0];
        return b;
    endfunction

    task automatic model_reset();
        m_cnt = 5'd0;
        for (int i = 0; i < 8; i++) m_regs[i] = 5'b11_000;
        q0.delete();
        q3.delete();
        for (int i = 0; i < 3; i++) q3.push_back(RST_B);
        exp0 = RST_B;
        exp3 = RST_B;
    endtask

    // One clock: drive inputs at the falling edge, compare at the next one.
    task automatic step(input logic c, input logic w, input logic [2:0] ch,
                        input logic [1:0] rl, input logic [2:0] con);
        bus0.cen = c;  bus0.wr = w;  bus0.wr_ch = ch;  bus0.wr_rl = rl;  bus0.wr_con = con;
        bus3.cen = c;  bus3.wr = w;  bus3.wr_ch = ch;  bus3.wr_rl = rl;  bus3.wr_con = con;
        if (c) begin
            bundle_t b;
            b = model_decode(m_cnt, m_regs[m_cnt[2:0]]);
            q0.push_back(b);
            q3.push_back(b);
            m_cnt = m_cnt + 5'd1;
            if (w) m_regs[ch] = {rl, con};
        end
        @(posedge clk);
        @(negedge clk);
        if (c) begin
            exp0 = q0.pop_front();
            exp3 = q3.pop_front();
        end
        tests_run++;
        if (out0 !== exp0) begin
            tests_failed++;
            $display("FAIL dly0_bundle got=%h required=%h", out0, exp0);
        end
        tests_run++;
        if (out3 !== exp3) begin
            tests_failed++;
            $display("FAIL dly3_bundle got=%h required=%h", out3, exp3);
        end
        $display("[TB] cen=%0b wr=%0b slot0=%0d rl0=%b con0=%0d slot3=%0d",
                 c, w, out0.slot, out0.rl, out0.con, out3.slot);
    endtask

    // Advance with cen high until the DLY=0 output shows the target slot.
    task automatic run_to(input logic [4:0] target);
        int n;
        n = 0;
        while (exp0.slot != target && n < 64) begin
            step(1'b1, 1'b0, 3'd0, 2'b00, 3'd0);
            n++;
        end
        tests_run++;
        if (out0.slot !== target) begin
            tests_failed++;
            $display("FAIL run_to_timeout got=%0d required=%0d", out0.slot, target);
        end
    endtask

    task automatic idle_inputs();
        bus0.cen = 1'b0; bus0.wr = 1'b0; bus0.wr_ch = 3'd0; bus0.wr_rl = 2'b00; bus0.wr_con = 3'd0;
        bus3.cen = 1'b0; bus3.wr = 1'b0; bus3.wr_ch = 3'd0; bus3.wr_rl = 2'b00; bus3.wr_con = 3'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (out0 !== RST_B) begin
            tests_failed++;
            $display("FAIL reset_dly0 got=%h required=%h", out0, RST_B);
        end
        tests_run++;
        if (out3 !== RST_B) begin
            tests_failed++;
            $display("FAIL reset_dly3 got=%h required=%h", out3, RST_B);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_frame();
        for (int i = 0; i < 34; i++) begin
            step(1'b1, 1'b0, 3'd0, 2'b00, 3'd0);
            tests_run++;
            if ((out0.m1 + out0.m2 + out0.c1 + out0.c2) != 1) begin
                tests_failed++;
                $display("FAIL enters_onehot got=%b%b%b%b required=one_hot",
                         out0.m1, out0.m2, out0.c1, out0.c2);
            end
        end
    endtask

    task automatic test_cen_third();
        for (int i = 0; i < 99; i++) begin
            step((i % 3) == 2, 1'b0, 3'd0, 2'b00, 3'd0);
        end
    endtask

    task automatic test_write_ch3();
        run_to(5'd2);
        step(1'b1, 1'b1, 3'd3, 2'b01, 3'd5);
        run_to(5'd11);
        tests_run++;
        if (out0.rl !== 2'b01 || out0.con !== 3'd5) begin
            tests_failed++;
            $display("FAIL ch3_slot11 got=%b/%0d required=01/5", out0.rl, out0.con);
        end
        run_to(5'd3);
        tests_run++;
        if (out0.rl !== 2'b01 || out0.con !== 3'd5) begin
            tests_failed++;
            $display("FAIL ch3_next_frame got=%b/%0d required=01/5", out0.rl, out0.con);
        end
    endtask

    task automatic test_collision();
        run_to(5'd4);
        // Counter is now 5: this write collides with the read of channel 5.
        step(1'b1, 1'b1, 3'd5, 2'b10, 3'd7);
        tests_run++;
        if (out0.slot !== 5'd5 || out0.rl !== 2'b11 || out0.con !== 3'd0) begin
            tests_failed++;
            $display("FAIL collision_old got=%0d:%b/%0d required=5:11/0",
                     out0.slot, out0.rl, out0.con);
        end
        run_to(5'd13);
        tests_run++;
        if (out0.rl !== 2'b10 || out0.con !== 3'd7) begin
            tests_failed++;
            $display("FAIL collision_new got=%b/%0d required=10/7", out0.rl, out0.con);
        end
    endtask

    task automatic test_dly3_writes();
        for (int i = 0; i < 48; i++) begin
            logic [2:0] ch;
            ch = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ch,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_reset_mid();
        run_to(5'd20);
        idle_inputs();
        rst = 1'b1;
        #1;
        tests_run++;
        if (out0 !== RST_B) begin
            tests_failed++;
            $display("FAIL midreset_dly0 got=%h required=%h", out0, RST_B);
        end
        tests_run++;
        if (out3 !== RST_B) begin
            tests_failed++;
            $display("FAIL midreset_dly3 got=%h required=%h", out3, RST_B);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 36; i++) begin
            step(1'b1, 1'b0, 3'd0, 2'b00, 3'd0);
            tests_run++;
            if (out0.rl !== 2'b11 || out0.con !== 3'd0) begin
                tests_failed++;
                $display("FAIL midreset_regs got=%b/%0d required=11/0", out0.rl, out0.con);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_frame();
        test_cen_third();
        test_write_ch3();
        test_collision();
        test_dly3_writes();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
